// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data SRAM arbiter: write-enable polarity,
// read-owner tags and the legal range of the starvation limit.
package mem_arbiter_pkg;

  localparam logic D_WEN_WRITE = 1'b0;
  localparam logic D_WEN_READ  = 1'b1;
  localparam logic M_WEN_WRITE = 1'b0;
  localparam logic M_WEN_READ  = 1'b1;
  localparam logic M_CSN_SEL   = 1'b0;
  localparam logic M_CSN_IDLE  = 1'b1;

  localparam int STARVE_MAX_MIN = 1;
  localparam int STARVE_MAX_LIM = 15;
  localparam int STREAK_W       = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Out-of-range limits are pulled back into 1..15 so the counter width always fits.
  function automatic logic [STREAK_W-1:0] clamp_starve(input int v);
    if (v < STARVE_MAX_MIN) return STREAK_W'(STARVE_MAX_MIN);
    else if (v > STARVE_MAX_LIM) return STREAK_W'(STARVE_MAX_LIM);
    else return STREAK_W'(v);
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating count of consecutive D grants taken while I is waiting (d_streak).
module arb_starve_cnt
  import mem_arbiter_pkg::*;
#(
  parameter logic [STREAK_W-1:0] MAX = 4'd4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [STREAK_W-1:0] cnt_o,
  output logic                full_o
);

  logic [STREAK_W-1:0] cnt_q;
  logic [STREAK_W-1:0] cnt_d;

  assign full_o = (cnt_q == MAX);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !full_o) begin
      cnt_d = cnt_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data access) arbiter in front of one single-port
// SRAM with 1-cycle read latency; D has priority, bounded by STARVE_MAX.
//
// Handshake: a requester raises REQ with stable address/data and holds them until
// it sees GNT in the same cycle; GNT is combinational from the current REQ, and the
// read response arrives as RVALID exactly one cycle after a read grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_GNT,
  output logic        I_RVALID,
  output logic [31:0] I_RDATA,
  input  logic        D_REQ,
  input  logic        D_WEN,
  input  logic [3:0]  D_BE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_GNT,
  output logic        D_RVALID,
  output logic [31:0] D_RDATA,
  output logic        M_CSN,
  output logic        M_WEN,
  output logic [3:0]  M_BE,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_DI,
  input  logic [31:0] M_DOUT
);

  localparam logic [STREAK_W-1:0] STARVE_LIM = clamp_starve(STARVE_MAX);

  logic                i_gnt_c;
  logic                d_gnt_c;
  logic [STREAK_W-1:0] d_streak;
  logic                streak_full;
  owner_e              owner_q;
  owner_e              owner_d;

  arb_starve_cnt #(
    .MAX (STARVE_LIM)
  ) u_starve_cnt (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (!I_REQ || i_gnt_c),
    .inc_i  (d_gnt_c),
    .cnt_o  (d_streak),
    .full_o (streak_full)
  );

  // Grant selection: D wins conflicts until it has starved I for STARVE_MAX grants.
  always_comb begin
    i_gnt_c = 1'b0;
    d_gnt_c = 1'b0;
    if (!RST) begin
      if (I_REQ && D_REQ) begin
        if (streak_full) begin
          i_gnt_c = 1'b1;
        end else begin
          d_gnt_c = 1'b1;
        end
      end else if (I_REQ) begin
        i_gnt_c = 1'b1;
      end else if (D_REQ) begin
        d_gnt_c = 1'b1;
      end
    end
  end

  assign I_GNT = i_gnt_c;
  assign D_GNT = d_gnt_c;

  always_comb begin
    M_CSN  = M_CSN_IDLE;
    M_WEN  = M_WEN_READ;
    M_BE   = 4'b0000;
    M_ADDR = 32'd0;
    M_DI   = 32'd0;
    if (i_gnt_c) begin
      M_CSN  = M_CSN_SEL;
      M_ADDR = I_ADDR;
    end else if (d_gnt_c) begin
      M_CSN  = M_CSN_SEL;
      M_WEN  = D_WEN;
      M_BE   = D_BE;
      M_ADDR = D_ADDR;
      M_DI   = D_WDATA;
    end
  end

  // Read owner: remembers who gets the SRAM output on the following cycle.
  always_comb begin
    owner_d = OWN_NONE;
    if (RST) begin
      owner_d = OWN_NONE;
    end else if (i_gnt_c) begin
      owner_d = OWN_I;
    end else if (d_gnt_c && (D_WEN == D_WEN_READ)) begin
      owner_d = OWN_D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // RST also masks RVALID so a read granted just before reset never completes.
  always_comb begin
    I_RVALID = (owner_q == OWN_I) && !RST;
    D_RVALID = (owner_q == OWN_D) && !RST;
  end

  assign I_RDATA = M_DOUT;
  assign D_RDATA = M_DOUT;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model with its own copy of memory.
module tb_mem_arbiter;

  localparam int SMAX = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        I_REQ = 1'b0;
  logic [31:0] I_ADDR = '0;
  logic        I_GNT, I_RVALID;
  logic [31:0] I_RDATA;
  logic        D_REQ = 1'b0;
  logic        D_WEN = 1'b1;
  logic [3:0]  D_BE = '0;
  logic [31:0] D_ADDR = '0;
  logic [31:0] D_WDATA = '0;
  logic        D_GNT, D_RVALID;
  logic [31:0] D_RDATA;
  logic        M_CSN, M_WEN;
  logic [3:0]  M_BE;
  logic [31:0] M_ADDR, M_DI;
  logic [31:0] M_DOUT = '0;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WEN(D_WEN), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .M_CSN(M_CSN), .M_WEN(M_WEN), .M_BE(M_BE), .M_ADDR(M_ADDR), .M_DI(M_DI), .M_DOUT(M_DOUT)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // counters
  int n_cmp = 0;
  int n_err = 0;
  int n_rv_dut = 0;
  int n_rv_exp = 0;

  // memories: sram_mem is the SRAM the DUT drives, ref_mem is the model's own copy
  logic [31:0] sram_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // SRAM: 1-cycle synchronous read, byte-enabled write
  always @(posedge CLK) begin
    logic [31:0] cur;
    if (M_CSN == 1'b0) begin
      cur = sram_mem.exists(M_ADDR) ? sram_mem[M_ADDR] : init_word(M_ADDR);
      if (M_WEN) M_DOUT <= cur;
      else sram_mem[M_ADDR] = merge(cur, M_DI, M_BE);
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    sram_mem[a] = v;
    ref_mem[a]  = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model state: 0 none, 1 I, 2 D
  int m_streak = 0;
  int m_own = 0;
  int mg = 0;
  int dut_g = 0;
  int i_wait = 0;

  // One clock cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic drive_cycle(input logic rst, input logic ireq, input logic [31:0] iaddr,
                             input logic dreq, input logic dwen, input logic [3:0] dbe,
                             input logic [31:0] daddr, input logic [31:0] wdata);
    logic exp_irv, exp_drv;
    logic [31:0] cur;
    int g;
    RST = rst; I_REQ = ireq; I_ADDR = iaddr;
    D_REQ = dreq; D_WEN = dwen; D_BE = dbe; D_ADDR = daddr; D_WDATA = wdata;
    @(negedge CLK);
    if (rst) g = 0;
    else if (ireq && dreq) g = (m_streak == SMAX) ? 1 : 2;
    else if (ireq) g = 1;
    else if (dreq) g = 2;
    else g = 0;
    mg = g;
    dut_g = I_GNT ? 1 : (D_GNT ? 2 : 0);
    exp_irv = !rst && (m_own == 1);
    exp_drv = !rst && (m_own == 2);

    chk("one_gnt", 32'(I_GNT & D_GNT), 32'd0);
    chk("i_gnt", 32'(I_GNT), 32'(g == 1));
    chk("d_gnt", 32'(D_GNT), 32'(g == 2));
    chk("m_csn", 32'(M_CSN), 32'(g == 0));
    chk("m_wen", 32'(M_WEN), 32'((g == 2) ? dwen : 1'b1));
    if (g == 1) begin
      chk("m_addr_i", M_ADDR, iaddr);
      chk("m_be_i", 32'(M_BE), 32'd0);
      chk("m_di_i", M_DI, 32'd0);
    end else if (g == 2) begin
      chk("m_addr_d", M_ADDR, daddr);
      chk("m_be_d", 32'(M_BE), 32'(dbe));
      chk("m_di_d", M_DI, wdata);
    end
    chk("i_rvalid", 32'(I_RVALID), 32'(exp_irv));
    chk("d_rvalid", 32'(D_RVALID), 32'(exp_drv));
    if (I_RVALID || D_RVALID) n_rv_dut++;
    if (exp_irv || exp_drv) begin
      n_rv_exp++;
      cur = exp_q.pop_front();
      if (exp_irv) chk("i_rdata", I_RDATA, cur);
      else chk("d_rdata", D_RDATA, cur);
    end

    if (rst) exp_q.delete();
    if (g == 1 || (g == 2 && dwen)) begin
      cur = (g == 1) ? iaddr : daddr;
      exp_q.push_back(ref_mem.exists(cur) ? ref_mem[cur] : init_word(cur));
    end else if (g == 2) begin
      cur = ref_mem.exists(daddr) ? ref_mem[daddr] : init_word(daddr);
      ref_mem[daddr] = merge(cur, wdata, dbe);
    end
    m_own = rst ? 0 : ((g == 1) ? 1 : ((g == 2 && dwen) ? 2 : 0));

    if (rst || !ireq || g == 1) m_streak = 0;
    else if (g == 2 && m_streak < SMAX) m_streak++;

    if (rst || !ireq) i_wait = 0;
    else begin
      i_wait++;
      if (g == 1) begin
        chk("i_wait", 32'(i_wait <= SMAX + 1), 32'd1);
        i_wait = 0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic rst);
    drive_cycle(rst, 1'b0, 32'd0, 1'b0, 1'b1, 4'h0, 32'd0, 32'd0);
  endtask

  int pat29 [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
  int pat30 [5]  = '{2, 2, 2, 2, 1};

  // random-phase pending requests
  logic        p_i, p_d, p_dwen, r_rst;
  logic [31:0] p_iaddr, p_daddr, p_wdata;
  logic [3:0]  p_be;

  initial begin
    @(posedge CLK); #1;
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // fetch from 0x40
    preload(32'h40, 32'h0000_0013);
    drive_cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 4'h0, 32'd0, 32'd0);
    chk("fetch_rvalid", 32'(I_RVALID), 32'd1);
    chk("fetch_rdata", I_RDATA, 32'h0000_0013);
    idle(1'b0);

    // write then read back 0x100
    drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h100, 32'hDEAD_BEEF);
    chk("wr_no_rvalid", 32'(D_RVALID), 32'd0);
    drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 4'hF, 32'h100, 32'd0);
    chk("rd_rvalid", 32'(D_RVALID), 32'd1);
    chk("rd_rdata", D_RDATA, 32'hDEAD_BEEF);
    chk("rd_no_irvalid", 32'(I_RVALID), 32'd0);
    idle(1'b0);

    // sustained conflict
    idle(1'b0);
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 4'hF, 32'h200, 32'd0);
      chk($sformatf("pat29_%0d", k), 32'(dut_g), 32'(pat29[k]));
    end
    idle(1'b0);

    // I drops after two lost conflicts, then returns with a fresh streak
    drive_cycle(1'b0, 1'b1, 32'h48, 1'b1, 1'b1, 4'hF, 32'h204, 32'd0);
    drive_cycle(1'b0, 1'b1, 32'h48, 1'b1, 1'b1, 4'hF, 32'h204, 32'd0);
    drive_cycle(1'b0, 1'b0, 32'h48, 1'b1, 1'b1, 4'hF, 32'h204, 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b0, 1'b1, 32'h48, 1'b1, 1'b1, 4'hF, 32'h208, 32'd0);
      chk($sformatf("pat30_%0d", k), 32'(dut_g), 32'(pat30[k]));
    end
    idle(1'b0);

    // reset right after a D read grant
    drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 4'hF, 32'h100, 32'd0);
    drive_cycle(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 4'hF, 32'h100, 32'd0);
    chk("rst_no_rvalid", 32'(D_RVALID), 32'd0);
    idle(1'b0);

    // random traffic
    p_i = 1'b0; p_d = 1'b0;
    p_iaddr = '0; p_daddr = '0; p_wdata = '0; p_be = '0; p_dwen = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      if (!p_i && $urandom_range(0, 99) < 50) begin
        p_i = 1'b1;
        p_iaddr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!p_d && $urandom_range(0, 99) < 60) begin
        p_d = 1'b1;
        p_dwen = 1'($urandom_range(0, 1));
        p_be = 4'($urandom_range(0, 15));
        p_daddr = 32'($urandom_range(0, 15)) << 2;
        p_wdata = $urandom;
      end
      r_rst = ($urandom_range(0, 499) == 0);
      drive_cycle(r_rst, p_i, p_iaddr, p_d, p_dwen, p_be, p_daddr, p_wdata);
      if (mg == 1) p_i = 1'b0;
      if (mg == 2) p_d = 1'b0;
      if (r_rst) begin
        p_i = 1'b0;
        p_d = 1'b0;
      end
    end
    idle(1'b0);
    idle(1'b0);
    chk("rvalid_count", 32'(n_rv_dut), 32'(n_rv_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive D-port grants while I_REQ is pending (legal range 1..15).
REQ-002 The block SHALL have port CLK, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, meaning the reset: synchronous, active-high.
REQ-004 The block SHALL have port I_REQ, input, 1, meaning the instruction-fetch read request.
REQ-005 The block SHALL have port I_ADDR, input, 32, meaning the fetch byte address.
REQ-006 The block SHALL have ports I_GNT output 1 (request accepted this cycle), I_RVALID output 1 (I_RDATA valid), and I_RDATA output 32 (fetch data).
REQ-007 The block SHALL have ports D_REQ input 1, D_WEN input 1 (0 = write, 1 = read), D_BE input 4, D_ADDR input 32, and D_WDATA input 32 (data-access request).
REQ-008 The block SHALL have ports D_GNT output 1, D_RVALID output 1, and D_RDATA output 32 (data-access response).
REQ-009 The block SHALL have ports M_CSN output 1 (0 = select), M_WEN output 1, M_BE output 4, M_ADDR output 32, M_DI output 32, and M_DOUT input 32, driving one shared single-port SRAM with 1-cycle synchronous read.

Function
REQ-010 Grants SHALL be combinational in the request cycle; at most one of I_GNT/D_GNT SHALL be high in any cycle.
REQ-011 With only one of I_REQ/D_REQ high, that requester SHALL be granted.
REQ-012 On conflict, D SHALL be granted unless d_streak == STARVE_MAX, in which case I SHALL be granted.
REQ-013 d_streak SHALL increment on each D grant while I_REQ is high, SHALL clear on any I grant or any cycle with I_REQ low, and SHALL saturate at STARVE_MAX.
REQ-014 On I grant, M_CSN=0, M_WEN=1, M_BE=4'b0000, M_ADDR=I_ADDR, and M_DI=0.
REQ-015 On D grant, M_CSN=0, M_WEN=D_WEN, M_BE=D_BE, M_ADDR=D_ADDR, and M_DI=D_WDATA.
REQ-016 With no grant, M_CSN=1 and M_WEN=1, with the other M_* outputs at don't-care (driven 0).
REQ-017 A registered owner flag SHALL record the read grant; the owner's RVALID SHALL be high exactly one cycle after its grant, and never for writes.
REQ-018 I_RDATA and D_RDATA SHALL both equal M_DOUT; only RVALID qualifies them.
REQ-019 A requester SHALL hold REQ and its address/data stable until GNT; the arbiter does not store requests.
REQ-020 Back-to-back grants SHALL be supported each cycle (throughput 1 access/cycle), including read-after-write to the same address.
REQ-021 Simultaneous REQ withdrawal and grant SHALL be impossible: grant is evaluated on the current-cycle REQ only.

Reset
REQ-022 While RST=1, I_GNT=0, D_GNT=0, M_CSN=1, and M_WEN=1.
REQ-023 At the first CLK edge with RST=1, I_RVALID=0, D_RVALID=0, d_streak=0, and owner=none, regardless of any in-flight read.
REQ-024 A read granted in the cycle before RST asserts SHALL NOT produce RVALID.

Structure
REQ-025 D_WEN/M_WEN encodings, the owner encoding (NONE/I/D), and the STARVE_MAX range limit SHALL reside in the shared core package.
REQ-026 One sub-module, arb_starve_cnt (the saturating d_streak counter with clear), is natural; all else is flat.

Verification
REQ-027 I_REQ only, I_ADDR=0x40, M_DOUT=0x00000013 -> I_GNT same cycle, M_CSN=0, and I_RVALID=1 with I_RDATA=0x13 the next cycle.
REQ-028 D write of D_ADDR=0x100, D_WDATA=0xDEADBEEF, then a D read of 0x100 -> M_WEN=0 then 1, D_RVALID only after the read, no I_RVALID.
REQ-029 I_REQ and D_REQ held high 10 cycles with STARVE_MAX=4 -> grant pattern D,D,D,D,I,D,D,D,D,I.
REQ-030 I_REQ dropped after 2 D-grant conflicts, then reasserted -> d_streak=0 and 4 further D grants before an I grant.
REQ-031 RST asserted the cycle after a D read grant -> D_RVALID stays 0, M_CSN=1, and all grants 0 during reset.
REQ-032 Random I/D traffic for 10k cycles -> never both GNTs, RVALID count equals read-grant count, and I waits at most STARVE_MAX+1 cycles.
